// File: rtl/umi_regif_arb_pkg.sv
// Shared types and constants for the register-bus arbiter.
package umi_regif_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Modulo-n increment of a requester index.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/umi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module umi_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/umi_regif_arbiter.sv
// Round-robin arbiter sharing one register-bus port among N requesters,
// with a ready timeout and registered completion back to the granted requester.
//
//   state  | meaning
//   IDLE   | waiting for any req_valid; winner latched on exit
//   ACCESS | strobe + latched fields on reg_*, waiting for reg_ready or timeout
//   DONE   | req_done pulse with response, round-robin pointer advanced
module umi_regif_arbiter
  import umi_regif_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 64,
  parameter int RW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*RW-1:0] req_wrdata,
  input  logic [2*N-1:0]  req_prot,
  output logic [N-1:0]    req_done,
  output logic [RW-1:0]   resp_rddata,
  output logic [1:0]      resp_err,
  output logic            reg_write,
  output logic            reg_read,
  output logic [AW-1:0]   reg_addr,
  output logic [RW-1:0]   reg_wrdata,
  output logic [1:0]      reg_prot,
  input  logic            reg_ready,
  input  logic [RW-1:0]   reg_rddata,
  input  logic [1:0]      reg_err,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          reg_write_q, reg_write_d;
  logic          reg_read_q, reg_read_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [RW-1:0] reg_wrdata_q, reg_wrdata_d;
  logic [1:0]    reg_prot_q, reg_prot_d;
  logic [N-1:0]  req_done_q, req_done_d;
  logic [RW-1:0] resp_rddata_q, resp_rddata_d;
  logic [1:0]    resp_err_q, resp_err_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  int            sel;

  umi_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    gnt_d         = gnt_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    reg_write_d   = reg_write_q;
    reg_read_d    = reg_read_q;
    reg_addr_d    = reg_addr_q;
    reg_wrdata_d  = reg_wrdata_q;
    reg_prot_d    = reg_prot_q;
    req_done_d    = '0;
    resp_rddata_d = '0;
    resp_err_d    = ERR_OK;
    sel           = int'(pick_idx);

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d      = ACCESS;
          g_d          = pick_idx;
          gnt_d        = pick_gnt;
          cnt_d        = '0;
          reg_write_d  = req_write[pick_idx];
          reg_read_d   = ~req_write[pick_idx];
          reg_addr_d   = req_addr[sel*AW +: AW];
          reg_wrdata_d = req_wrdata[sel*RW +: RW];
          reg_prot_d   = req_prot[sel*2 +: 2];
        end
      end

      ACCESS: begin
        if (reg_ready) begin
          state_d       = DONE;
          reg_write_d   = 1'b0;
          reg_read_d    = 1'b0;
          req_done_d    = gnt_q;
          resp_rddata_d = reg_write_q ? '0 : reg_rddata;
          resp_err_d    = reg_err;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th strobe cycle without ready.
          state_d       = DONE;
          reg_write_d   = 1'b0;
          reg_read_d    = 1'b0;
          req_done_d    = gnt_q;
          resp_err_d    = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = IW'(wrap_inc(int'(g_q), N));
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      g_q           <= '0;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      reg_write_q   <= 1'b0;
      reg_read_q    <= 1'b0;
      reg_addr_q    <= '0;
      reg_wrdata_q  <= '0;
      reg_prot_q    <= '0;
      req_done_q    <= '0;
      resp_rddata_q <= '0;
      resp_err_q    <= ERR_OK;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      g_q           <= g_d;
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      reg_write_q   <= reg_write_d;
      reg_read_q    <= reg_read_d;
      reg_addr_q    <= reg_addr_d;
      reg_wrdata_q  <= reg_wrdata_d;
      reg_prot_q    <= reg_prot_d;
      req_done_q    <= req_done_d;
      resp_rddata_q <= resp_rddata_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign req_done    = req_done_q;
  assign resp_rddata = resp_rddata_q;
  assign resp_err    = resp_err_q;
  assign reg_write   = reg_write_q;
  assign reg_read    = reg_read_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wrdata  = reg_wrdata_q;
  assign reg_prot    = reg_prot_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_umi_regif_arbiter.sv
// Scoreboard bench for umi_regif_arbiter: round-robin order, responses, timeout and reset.
module tb_umi_regif_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int RW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*RW-1:0] req_wrdata;
  logic [2*N-1:0]  req_prot;
  logic [N-1:0]    req_done;
  logic [RW-1:0]   resp_rddata;
  logic [1:0]      resp_err;
  logic            reg_write, reg_read;
  logic [AW-1:0]   reg_addr;
  logic [RW-1:0]   reg_wrdata;
  logic [1:0]      reg_prot;
  logic            reg_ready;
  logic [RW-1:0]   reg_rddata;
  logic [1:0]      reg_err;
  logic            busy;

  umi_regif_arbiter #(.N(N), .AW(AW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wrdata(req_wrdata), .req_prot(req_prot),
    .req_done(req_done), .resp_rddata(resp_rddata), .resp_err(resp_err),
    .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
    .reg_wrdata(reg_wrdata), .reg_prot(reg_prot),
    .reg_ready(reg_ready), .reg_rddata(reg_rddata), .reg_err(reg_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [1:0]  prot;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          len;
  } exp_t;

  typedef struct {
    int         delay;
    logic [1:0] err;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  logic [31:0] mmem[16];   // reference model view of the register array
  logic [31:0] smem[16];   // array behind the bus responder
  logic        f_write[N];
  logic [63:0] f_addr[N];
  logic [31:0] f_wdata[N];
  logic [1:0]  f_prot[N];
  int          model_ptr;
  int          plan_mode;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic randomize_fields(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        f_write[i] = 1'($urandom_range(0, 1));
        f_addr[i]  = {$urandom, $urandom};
        f_wdata[i] = $urandom;
        f_prot[i]  = 2'($urandom);
      end
    end
  endtask

  // Reference: serve the pending set in round-robin order from model_ptr.
  task automatic issue_round(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int p, g, c, r;
    plan_t pl;
    exp_t e;
    pend = mask;
    p = model_ptr;
    for (int k = 0; k < N; k++) begin
      if (pend == '0) break;
      g = -1;
      for (int j = 0; j < N; j++) begin
        c = (p + j) % N;
        if (pend[c] && g < 0) g = c;
      end
      pend[g] = 1'b0;
      p = (g + 1) % N;
      case (plan_mode)
        1: begin pl.delay = 0; pl.err = 2'b00; end
        2: begin pl.delay = TO + 4; pl.err = 2'b00; end
        3: begin pl.delay = 3; pl.err = 2'b11; end
        4: begin pl.delay = (k == 0) ? TO + 4 : 0; pl.err = 2'($urandom); end
        default: begin
          r = $urandom_range(0, 9);
          pl.err = 2'($urandom);
          if (r <= 4) pl.delay = 0;
          else if (r <= 6) pl.delay = $urandom_range(1, 3);
          else if (r == 7) pl.delay = TO - 1;
          else if (r == 8) pl.delay = TO + 4;
          else pl.delay = 2;
        end
      endcase
      plan_q.push_back(pl);
      e.idx = g; e.wr = f_write[g]; e.addr = f_addr[g];
      e.wdata = f_wdata[g]; e.prot = f_prot[g];
      if (pl.delay >= TO) begin
        e.len = TO; e.err = 2'b10; e.rdata = '0;
      end else begin
        e.len = pl.delay + 1; e.err = pl.err;
        e.rdata = f_write[g] ? 32'h0 : mmem[f_addr[g][5:2]];
        if (f_write[g]) mmem[f_addr[g][5:2]] = f_wdata[g];
      end
      exp_q.push_back(e);
    end
    model_ptr = p;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req_write[i]            = f_write[i];
        req_addr[i*AW +: AW]    = f_addr[i];
        req_wrdata[i*RW +: RW]  = f_wdata[i];
        req_prot[i*2 +: 2]      = f_prot[i];
        req_valid[i]            = 1'b1;
      end
    end
  endtask

  task automatic wait_round();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || req_valid != '0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("round_complete", 64'((exp_q.size() == 0) && (req_valid == '0)), 64'd1);
    if (exp_q.size() != 0 || req_valid != '0) begin
      exp_q.delete();
      plan_q.delete();
      req_valid = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_ptr = 0;
    end
  endtask

  // Bus responder: ready after the planned number of strobe cycles.
  initial begin : responder
    plan_t cur;
    int s_cnt;
    bit s_active, s_wr;
    logic [63:0] s_addr;
    logic [31:0] s_wd;
    reg_ready = 1'b0; reg_rddata = '0; reg_err = '0;
    s_active = 0; s_cnt = 0; s_wr = 0; s_addr = '0; s_wd = '0;
    cur.delay = 0; cur.err = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        s_active = 0; reg_ready = 1'b0;
        continue;
      end
      if (s_active && !(reg_read || reg_write)) begin
        if (reg_ready && s_wr) smem[s_addr[5:2]] = s_wd;
        s_active = 0; reg_ready = 1'b0;
      end
      if (!s_active && (reg_read || reg_write)) begin
        s_active = 1; s_cnt = 0;
        s_addr = reg_addr; s_wr = reg_write; s_wd = reg_wrdata;
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else begin cur.delay = 0; cur.err = 2'b00; end
      end
      if (s_active) begin
        if (s_cnt == cur.delay) begin
          reg_ready = 1'b1; reg_rddata = smem[s_addr[5:2]]; reg_err = cur.err;
        end else begin
          reg_ready = 1'b0; reg_rddata = $urandom; reg_err = 2'($urandom);
        end
        s_cnt++;
      end
    end
  end

  // Monitor: compares every strobe and every req_done against the scoreboard.
  initial begin : monitor
    exp_t e;
    int m_len, m_gap;
    bit m_bad, m_prev, m_arm, strobe;
    m_len = 0; m_gap = 0; m_bad = 0; m_prev = 0; m_arm = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_len = 0; m_bad = 0; m_prev = 0; m_arm = 0;
        continue;
      end
      strobe = reg_read | reg_write;
      if (m_arm) m_gap++;
      if (strobe) begin
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (reg_write !== e.wr || reg_read !== !e.wr || reg_addr !== e.addr ||
              reg_wrdata !== e.wdata || reg_prot !== e.prot) m_bad = 1;
        end
        if (m_len == 0 && m_arm) begin
          check("issue_gap", 64'(m_gap), 64'd2);
          m_arm = 0;
        end
        m_len++;
      end
      if (req_done != '0) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(req_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_vector", 64'(req_done), 64'(1 << e.idx));
          check("resp_rddata", 64'(resp_rddata), 64'(e.rdata));
          check("resp_err", 64'(resp_err), 64'(e.err));
          check("strobe_len", 64'(m_len), 64'(e.len));
          check("bus_fields", 64'(m_bad), 64'd0);
          check("done_after_strobe", 64'(m_prev), 64'd1);
          if (exp_q.size() > 0) begin m_arm = 1; m_gap = 0; end
        end
        req_valid = req_valid & ~req_done;
        m_len = 0; m_bad = 0;
      end
      m_prev = strobe;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stim
    logic [N-1:0] mask;
    int cyc;
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wrdata = '0; req_prot = '0;
    model_ptr = 0; plan_mode = 0;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = $urandom;
      smem[i] = mmem[i];
    end
    for (int i = 0; i < N; i++) begin
      f_write[i] = 1'b0; f_addr[i] = '0; f_wdata[i] = '0; f_prot[i] = '0;
    end
    #1;
    check("rst_req_done", 64'(req_done), 64'd0);
    check("rst_strobes", 64'({reg_read, reg_write}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_reg_addr", reg_addr, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single read with ready tied high: strobe cycle 1, done cycle 2
    mmem[4] = 32'hDEADBEEF; smem[4] = 32'hDEADBEEF;
    f_write[0] = 1'b0; f_addr[0] = 64'h10; f_wdata[0] = 32'h0; f_prot[0] = 2'b01;
    plan_mode = 1;
    issue_round(4'b0001);
    @(negedge clk);
    check("c1_reg_read", 64'(reg_read), 64'd1);
    check("c1_reg_addr", reg_addr, 64'h10);
    check("c1_busy", 64'(busy), 64'd1);
    check("c1_no_done", 64'(req_done), 64'd0);
    @(negedge clk);
    check("c2_req_done", 64'(req_done), 64'd1);
    check("c2_rddata", 64'(resp_rddata), 64'hDEADBEEF);
    check("c2_strobe_low", 64'(reg_read), 64'd0);
    wait_round();

    // ready low 3 cycles then error 11
    randomize_fields(4'b0010); plan_mode = 3;
    issue_round(4'b0010); wait_round();

    // stuck ready: first access times out, the next is still granted
    randomize_fields(4'b0101); plan_mode = 4;
    issue_round(4'b0101); wait_round();

    // all four continuously valid
    randomize_fields(4'b1111); plan_mode = 1;
    issue_round(4'b1111); wait_round();

    plan_mode = 0;
    for (int r = 0; r < 40; r++) begin
      mask = 4'($urandom_range(1, 15));
      randomize_fields(mask);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue_round(mask);
      wait_round();
    end

    // reset in the middle of an access
    randomize_fields(4'b0011); plan_mode = 2;
    issue_round(4'b0011);
    cyc = 0;
    while (!(reg_read || reg_write) && cyc < 20) begin @(negedge clk); cyc++; end
    check("rst_strobe_seen", 64'(reg_read | reg_write), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_strobes", 64'({reg_read, reg_write}), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_req_done", 64'(req_done), 64'd0);
    exp_q.delete(); plan_q.delete();
    model_ptr = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    plan_mode = 1;
    issue_round(4'b0011);
    wait_round();

    repeat (3) @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/umi_regif_arbiter.md
# umi_regif_arbiter

Round-robin arbiter and sequencer that shares one register-bus port (the `reg_*` side of `umi_regif`) between N register requesters, e.g. a UMI-driven `umi_regif` and a local debug/boot sequencer. It grants one requester at a time and drives the strobe/address/data onto the shared port, holding them until `reg_ready`. It returns read data and error status to the granted requester and enforces a ready timeout. It sits between the requesters and the register array.

## Interface
- N, 2, number of requesters (2..8)
- AW, 64, address width
- RW, 32, register data width
- TIMEOUT, 255, max cycles waiting for `reg_ready` before forced error completion (1..65535)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  N  requester i has a pending access; fields held stable until its `req_done`
- req_write  input  N  1 = write, 0 = read
- req_addr  input  N*AW  per-requester address, slice i at [i*AW +: AW]
- req_wrdata  input  N*RW  per-requester write data
- req_prot  input  2*N  per-requester protection bits
- req_done  output  N  one-cycle completion pulse to requester i, one-hot or zero
- resp_rddata  output  RW  read data, valid in the `req_done` cycle
- resp_err  output  2  status, valid in the `req_done` cycle (00 OK, 10 timeout, else passed from `reg_err`)
- reg_write  output  1  write strobe to shared port
- reg_read  output  1  read strobe to shared port
- reg_addr  output  AW  address to shared port
- reg_wrdata  output  RW  write data to shared port
- reg_prot  output  2  protection to shared port
- reg_ready  input  1  shared port accepts/completes current access
- reg_rddata  input  RW  read data, sampled when `reg_ready` is high
- reg_err  input  2  error, sampled when `reg_ready` is high
- busy  output  1  high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any `req_valid`, pick the winner g = first set bit at or after `rr_ptr` (wrapping). Latch g and its write/addr/wrdata/prot into registers. Clear the timeout counter. Go to ACCESS.
- ACCESS: drive the latched fields. Assert exactly one of `reg_write`/`reg_read`. Hold all until `reg_ready`.
  - On `reg_ready`: capture `reg_rddata` (reads) and `reg_err`, deassert strobes, go to DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT without `reg_ready`, deassert strobes, set err=2'b10, rddata=0, go to DONE.
- DONE: pulse `req_done[g]`, present captured `resp_rddata` and `resp_err`, set `rr_ptr` = (g+1) mod N, go to IDLE.
- Writes return `resp_rddata` = 0.
- `req_valid` deasserted by a requester after latch is ignored; the access completes and `req_done` still pulses. This is a protocol violation and needs no special handling.
- Requester i must not reassert `req_valid` for a new access in the `req_done` cycle unless it intends a new request; a held `req_valid` is treated as a new request in the next IDLE.

## Timing
- Reset values: all outputs 0, `rr_ptr` = 0, state IDLE, counter 0. Async assert clears immediately, including mid-ACCESS: strobes drop at once and no `req_done` is issued. Deassert is synchronised by the integrator.
- Latency with `reg_ready` tied high: `req_valid` seen at cycle 0, strobe at cycle 1, `req_done` at cycle 2. Next grant is evaluated at cycle 3, giving a 3-cycle minimum per access.
- General case: `req_done` comes one cycle after the `reg_ready` cycle.
- Timeout: strobe held exactly TIMEOUT cycles; `req_done` follows on the next cycle.
- All outputs are registered; no combinational path from `req_*` or `reg_ready` to any output.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0. No requester waits more than N-1 other accesses.

## Structure
- Package `umi_regif_arb_pkg`: state enum (IDLE, ACCESS, DONE), err constants ERR_OK=2'b00, ERR_TIMEOUT=2'b10.
- Sub-module `umi_rr_pick`, combinational, parameter N: inputs request vector and pointer; outputs one-hot grant and index.
- Timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- Single read, N=2, req 0 addr 0x10, `reg_ready`=1, regfile[4]=0xDEADBEEF -> `reg_read` in cycle 1 with `reg_addr`=0x10, `req_done[0]` in cycle 2 with rddata 0xDEADBEEF, err 00.
- Both requesters valid continuously for 6 accesses -> grant order 0,1,0,1,0,1; `req_done` never two-hot; writes to 0x0/0x4 land in regfile.
- `reg_ready` held low 3 cycles, `reg_err`=2'b11 at ready -> strobe held 4 cycles with stable addr/data; `req_done` has err 11.
- TIMEOUT=8, `reg_ready` stuck low -> strobe exactly 8 cycles, then `req_done` with err 10, rddata 0; next requester is granted afterward.
- `reset` pulsed mid-ACCESS -> strobes, `busy`, and `req_done` go 0 asynchronously. After release, a pending `req_valid[1]` is granted only after `req_valid[0]` per `rr_ptr`=0.
- N=4, only req 3 valid, then req 1 -> req 3 served, then req 1, with no idle cycles beyond the 3-cycle minimum.
